alu_arbiter: RTL and testbench

//  Shares the single 8-bit combinational alu between two requesters (e.g. instruction path, address path).

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-port arbiter that sequences requests through a shared 8-bit
//            combinational alu with registered alu inputs.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [3:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [7:0]       rsp_c,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_op,
  input  logic [7:0]       alu_c,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_grant;
  logic             r_last_grant;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [3:0]       r_alu_op;
  logic [7:0]       r_c;
  logic             r_z;
  logic             r_n;
  logic [CNT_W-1:0] r_op_count;

  logic             w_any;
  logic             w_grant;
  logic             w_rsp_hs;

  assign w_any = req0_valid | req1_valid;

  // w_grant is only meaningful while w_any is high
  always_comb begin
    w_grant = 1'b0;
    if (RR_EN != 0) begin
      if (req0_valid && req1_valid) w_grant = ~r_last_grant;
      else                          w_grant = req1_valid;
    end else begin
      w_grant = ~req0_valid;
    end
  end

  assign w_rsp_hs = (r_state == ST_RESP) &&
                    ((!r_grant && rsp0_ready) || (r_grant && rsp1_ready));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any)    w_state_nxt = ST_EXEC;
      ST_EXEC:               w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_hs) w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_alu_a      <= 8'h00;
      r_alu_b      <= 8'h00;
      r_alu_op     <= 4'h0;
      r_c          <= 8'h00;
      r_z          <= 1'b0;
      r_n          <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant  <= w_grant;
            r_alu_a  <= w_grant ? req1_a  : req0_a;
            r_alu_b  <= w_grant ? req1_b  : req0_b;
            r_alu_op <= w_grant ? req1_op : req0_op;
          end
        end
        ST_EXEC: begin
          r_c <= alu_c;
          r_z <= (alu_c == 8'h00);
          r_n <= alu_c[7];
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_op_count   <= r_op_count + c_CNT_ONE;
            r_last_grant <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = (r_state == ST_IDLE) && w_any && !w_grant;
  assign req1_ready = (r_state == ST_IDLE) && w_any &&  w_grant;
  assign rsp0_valid = (r_state == ST_RESP) && !r_grant;
  assign rsp1_valid = (r_state == ST_RESP) &&  r_grant;
  assign rsp_c      = r_c;
  assign rsp_z      = r_z;
  assign rsp_n      = r_n;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign busy       = (r_state != ST_IDLE);
  assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter with an alu model and a
//            response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp_c, alu_a, alu_b, alu_c;
  logic       rsp_z, rsp_n, busy;
  logic [3:0] alu_op;
  logic [3:0] op_count;

  // fixed-priority instance
  logic        p_req0_valid, p_req1_valid;
  logic        p_req0_ready, p_req1_ready, p_rsp0_valid, p_rsp1_valid;
  logic [7:0]  p_rsp_c, p_alu_a, p_alu_b, p_alu_c;
  logic        p_rsp_z, p_rsp_n, p_busy;
  logic [3:0]  p_alu_op;
  logic [15:0] p_op_count;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op);
    logic [7:0] r;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a ^ b;
      4'h3: r = ~a;
      4'h4: r = a << 1;
      4'h5: r = a >> 1;
      4'h6: r = a + b;
      4'h7: r = a - b;
      4'h8: r = a + 8'h01;
      4'h9: r = 8'h00 - a;
      4'hA: r = a - 8'h01;
      4'hB: r = b;
      4'hC: r = a;
      4'hD: r = {a[3:0], a[7:4]};
      4'hE: r = 8'h00;
      default: for (int i = 0; i < 8; i++) r[i] = a[7-i];
    endcase
    return r;
  endfunction

  assign alu_c   = alu_f(alu_a, alu_b, alu_op);
  assign p_alu_c = alu_f(p_alu_a, p_alu_b, p_alu_op);

  alu_arbiter #(.RR_EN(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_n(rsp_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.RR_EN(0), .CNT_W(16)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(p_req0_valid), .req0_ready(p_req0_ready), .req0_a(8'h03), .req0_b(8'h04),
    .req0_op(4'h6), .rsp0_valid(p_rsp0_valid), .rsp0_ready(1'b1),
    .req1_valid(p_req1_valid), .req1_ready(p_req1_ready), .req1_a(8'h09), .req1_b(8'h02),
    .req1_op(4'h7), .rsp1_valid(p_rsp1_valid), .rsp1_ready(1'b1),
    .rsp_c(p_rsp_c), .rsp_z(p_rsp_z), .rsp_n(p_rsp_n),
    .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_op(p_alu_op), .alu_c(p_alu_c),
    .busy(p_busy), .op_count(p_op_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       port;
    logic [7:0] c;
  } exp_t;
  exp_t       q[$];
  logic [3:0] exp_cnt   = 4'h0;
  logic       last_port = 1'b1;

  // scoreboard: push on accept, pop on response handshake
  always @(negedge clk) begin
    exp_t e;
    chk("op_count_model", {28'h0, op_count}, {28'h0, exp_cnt});
    chk("rsp_valid_onehot", {31'h0, rsp0_valid & rsp1_valid}, 32'h0);
    chk("req_ready_onehot", {31'h0, req0_ready & req1_ready}, 32'h0);
    if (rst) begin
      q.delete();
      exp_cnt   = 4'h0;
      last_port = 1'b1;
    end else begin
      if (req0_valid && req0_ready) q.push_back('{1'b0, alu_f(req0_a, req0_b, req0_op)});
      if (req1_valid && req1_ready) q.push_back('{1'b1, alu_f(req1_a, req1_b, req1_op)});
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_rsp", 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          chk("sb_port", {31'h0, rsp1_valid}, {31'h0, e.port});
          chk("sb_c", {24'h0, rsp_c}, {24'h0, e.c});
          chk("sb_z", {31'h0, rsp_z}, {31'h0, (e.c == 8'h00)});
          chk("sb_n", {31'h0, rsp_n}, {31'h0, e.c[7]});
        end
        exp_cnt   = exp_cnt + 4'h1;
        last_port = rsp1_valid;
      end
    end
  end

  task automatic do_op(input logic p, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, output int acc_cyc, output int rsp_cyc);
    int n;
    @(posedge clk); #1;
    if (!p) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else    begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(p ? req1_ready : req0_ready) && n < 20);
    if (n >= 20) chk("accept_timeout", 32'h0, 32'h1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    // scramble request data after accept; the latched operands must be used
    if (!p) begin req0_valid = 1'b0; req0_a = ~a; req0_b = ~b; req0_op = ~op; end
    else    begin req1_valid = 1'b0; req1_a = ~a; req1_b = ~b; req1_op = ~op; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(p ? rsp1_valid : rsp0_valid) && n < 20);
    if (n >= 20) chk("rsp_timeout", 32'h0, 32'h1);
    rsp_cyc = cyc;
  endtask

  typedef struct {
    logic       port;
    logic [7:0] a, b;
    logic [3:0] op;
    logic [7:0] c;
    logic       z, n;
  } vec_t;
  vec_t vt[8];

  initial begin
    int ac, rc, n, g_cyc, prev_cyc;
    logic exp_g, g;
    vt[0] = '{1'b0, 8'h0F, 8'h01, 4'h6, 8'h10, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h05, 8'h05, 4'h7, 8'h00, 1'b1, 1'b0};
    vt[2] = '{1'b1, 8'h01, 8'h00, 4'h9, 8'hFF, 1'b0, 1'b1};
    vt[3] = '{1'b0, 8'hF0, 8'h3C, 4'h0, 8'h30, 1'b0, 1'b0};
    vt[4] = '{1'b0, 8'h80, 8'h01, 4'h1, 8'h81, 1'b0, 1'b1};
    vt[5] = '{1'b1, 8'hAA, 8'h55, 4'h2, 8'hFF, 1'b0, 1'b1};
    vt[6] = '{1'b0, 8'h01, 8'h00, 4'hF, 8'h80, 1'b0, 1'b1};
    vt[7] = '{1'b1, 8'hFF, 8'h01, 4'h6, 8'h00, 1'b1, 1'b0};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_a = 8'h0; req0_b = 8'h0; req0_op = 4'h0;
    req1_a = 8'h0; req1_b = 8'h0; req1_op = 4'h0;
    p_req0_valid = 1'b0; p_req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp0_valid", {31'h0, rsp0_valid}, 32'h0);
    chk("rst_rsp1_valid", {31'h0, rsp1_valid}, 32'h0);
    chk("rst_rsp_c", {24'h0, rsp_c}, 32'h0);
    chk("rst_alu", {12'h0, alu_a, alu_b, alu_op}, 32'h0);
    chk("rst_op_count", {28'h0, op_count}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(vt[i].port, vt[i].a, vt[i].b, vt[i].op, ac, rc);
      chk($sformatf("vec%0d_latency", i), rc - ac, 32'd2);
      chk($sformatf("vec%0d_rsp_c", i), {24'h0, rsp_c}, {24'h0, vt[i].c});
      chk($sformatf("vec%0d_z", i), {31'h0, rsp_z}, {31'h0, vt[i].z});
      chk($sformatf("vec%0d_n", i), {31'h0, rsp_n}, {31'h0, vt[i].n});
      @(negedge clk);
      chk($sformatf("vec%0d_op_count", i), {28'h0, op_count}, i + 1);
    end

    // round-robin contention
    @(posedge clk); #1;
    exp_g = ~last_port;
    req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04; req0_op = 4'h6;
    req1_valid = 1'b1; req1_a = 8'h09; req1_b = 8'h02; req1_op = 4'h7;
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(req0_ready || req1_ready) && n < 10);
      if (n >= 10) chk("rr_timeout", 32'h0, 32'h1);
      g = req1_ready; g_cyc = cyc;
      chk($sformatf("rr_grant%0d", k), {31'h0, g}, {31'h0, exp_g});
      if (k > 0) chk($sformatf("rr_interval%0d", k), g_cyc - prev_cyc, 32'd3);
      prev_cyc = g_cyc;
      exp_g = ~exp_g;
      @(posedge clk);
    end
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);

    // fixed-priority contention
    #1 p_req0_valid = 1'b1; p_req1_valid = 1'b1;
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(p_req0_ready || p_req1_ready) && n < 10);
      if (n >= 10) chk("fp_timeout", 32'h0, 32'h1);
      chk($sformatf("fp_grant%0d", k), {30'h0, p_req1_ready, p_req0_ready}, 32'h1);
      if (k > 0) chk($sformatf("fp_interval%0d", k), cyc - prev_cyc, 32'd3);
      prev_cyc = cyc;
      @(posedge clk);
    end
    #1 p_req0_valid = 1'b0; p_req1_valid = 1'b0;

    // backpressure on port 0 while port 1 waits
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20; req0_op = 4'h1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 10);
    if (n >= 10) chk("bp_accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'h01; req1_op = 4'h6;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp0_valid && n < 10);
    if (n >= 10) chk("bp_rsp_timeout", 32'h0, 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp0_valid_held", {31'h0, rsp0_valid}, 32'h1);
      chk("bp_rsp_c_held", {24'h0, rsp_c}, 32'h30);
      chk("bp_req1_ready_low", {31'h0, req1_ready}, 32'h0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_req1_ready_before_hs", {31'h0, req1_ready}, 32'h0);
    @(negedge clk);
    chk("bp_req1_ready_after_hs", {31'h0, req1_ready}, 32'h1);
    @(posedge clk); #1 req1_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp1_valid && n < 10);
    if (n >= 10) chk("bp_rsp1_timeout", 32'h0, 32'h1);
    chk("bp_rsp1_c", {24'h0, rsp_c}, 32'h08);

    // reset asserted during EXEC
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'h22; req0_b = 8'h11; req0_op = 4'h6;
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 10);
    if (n >= 10) chk("rst_op_accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_exec", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_rsp0_valid", {31'h0, rsp0_valid}, 32'h0);
    chk("midrst_alu_a", {24'h0, alu_a}, 32'h0);
    chk("midrst_op_count", {28'h0, op_count}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_rsp", {30'h0, rsp1_valid, rsp0_valid}, 32'h0);
    end
    do_op(1'b0, 8'h33, 8'h01, 4'h7, ac, rc);
    chk("post_rst_latency", rc - ac, 32'd2);
    chk("post_rst_rsp_c", {24'h0, rsp_c}, 32'h32);
    @(negedge clk);
    chk("post_rst_op_count", {28'h0, op_count}, 32'h1);

    // counter wrap: 15 more completions bring the 4-bit count back to 0
    for (int k = 0; k < 15; k++) begin
      do_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'($urandom), ac, rc);
      if (k == 14) chk("wrap_pre", {28'h0, op_count}, 32'hF);
    end
    @(negedge clk);
    chk("wrap_zero", {28'h0, op_count}, 32'h0);
    chk("sb_drained", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
